// File: rtl/riscv_pkg.sv
// Shared types for the unified-memory port arbiter.
//   arb_state_t : arbiter FSM state (idle / command on bus / awaiting response)
//   arb_owner_t : which requester owns the outstanding transaction
//   STARVE_W    : width of the fetch starvation counter (covers STARVE_MAX up to 15)
package riscv_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } arb_owner_t;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port unified memory between instruction fetch
// (IF) and load/store (MEM). One transaction is outstanding at a time; data
// requests win conflicts, except that fetch is forced through after
// STARVE_MAX consecutive data grants made while a fetch was waiting. A fetch
// in flight when IF is flushed still completes on the bus, but its response
// is swallowed.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_req/if_addr/if_flush        fetch request, PC, flush (PCSrc)
//   if_valid/if_rdata              fetch response pulse and instruction
//   d_req/d_we/d_be/d_addr/d_wdata load/store request
//   d_valid/d_rdata                load data or store acknowledge pulse
//   mem_req/mem_we/mem_be/
//   mem_addr/mem_wdata             registered memory command, held until mem_gnt
//   mem_gnt                        memory accepted the command
//   mem_rvalid/mem_rdata           memory response beat (reads and writes)
//   stall_if/stall_mem             request pending and not answered this cycle
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  // fetch side
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_valid,
  output logic [XLEN-1:0]     if_rdata,
  // load/store side
  input  logic                d_req,
  input  logic                d_we,
  input  logic [XLEN/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [XLEN-1:0]     d_wdata,
  output logic                d_valid,
  output logic [XLEN-1:0]     d_rdata,
  // memory side
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  // pipeline hazard controls
  output logic                stall_if,
  output logic                stall_mem
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q, owner_d;
  logic                kill_q, kill_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                we_q, we_d;
  logic [XLEN/8-1:0]   be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;

  // A fetch coinciding with a flush is for a dead PC and is never latched.
  logic fetch_ok;
  logic fetch_forced;
  logic if_flush_own;

  assign fetch_ok     = if_req & ~if_flush;
  assign fetch_forced = fetch_ok & (starve_q == STARVE_LIM);
  assign if_flush_own = if_flush & (owner_q == OWN_IF);

  // Command fields come straight from registers; read data is shared.
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    owner_d   = owner_q;
    kill_d    = kill_q;
    starve_d  = starve_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_req   = 1'b0;
    if_valid  = 1'b0;
    d_valid   = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (d_req && !fetch_forced) begin
          state_d = ARB_ISSUE;
          owner_d = OWN_D;
          we_d    = d_we;
          be_d    = d_be;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          // Count data grants that overtook a waiting fetch.
          if (!if_req)
            starve_d = '0;
          else if (starve_q != STARVE_LIM)
            starve_d = starve_q + 1'b1;
        end else if (fetch_ok) begin
          state_d  = ARB_ISSUE;
          owner_d  = OWN_IF;
          we_d     = 1'b0;
          be_d     = '1;
          addr_d   = if_addr;
          wdata_d  = '0;
          starve_d = '0;
        end else if (!if_req) begin
          starve_d = '0;
        end
      end

      ARB_ISSUE: begin
        mem_req = 1'b1;
        if (if_flush_own) kill_d = 1'b1;
        if (mem_gnt) state_d = ARB_WAIT;
      end

      ARB_WAIT: begin
        // Responses are only honoured here; rvalid in IDLE/ISSUE is stray.
        if (mem_rvalid) begin
          if_valid = (owner_q == OWN_IF) & ~kill_q & ~if_flush;
          d_valid  = (owner_q == OWN_D);
          state_d  = ARB_IDLE;
          owner_d  = OWN_NONE;
          kill_d   = 1'b0;
        end else if (if_flush_own) begin
          kill_d = 1'b1;
        end
      end

      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
        kill_d  = 1'b0;
      end
    endcase

    // NOTE: blocking assignments are right in combinational logic; the
    // valids computed above are read back here in the same evaluation.
    stall_if  = if_req & ~if_valid;
    stall_mem = d_req & ~d_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the command/data registers are reset too, not just control,
      // so the memory bus never shows stale fields after reset.
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_NONE;
      kill_q   <= 1'b0;
      starve_q <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      kill_q   <= kill_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. A small memory responder grants
// commands after a programmable hold and answers after a programmable delay,
// logging every granted command. All stimulus changes on the falling edge;
// outputs are sampled 1 time unit later, before the next rising edge.
module tb_mem_port_arbiter;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req, if_flush, if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic [XLEN-1:0]   if_rdata;
  logic              d_req, d_we, d_valid;
  logic [XLEN/8-1:0] d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [XLEN-1:0]   d_wdata, d_rdata;
  logic              mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [XLEN/8-1:0] mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata, mem_rdata;
  logic              stall_if, stall_mem;

  // responder outputs and a bench-forced stray response
  logic              rsp_gnt, rsp_rvalid, force_rvalid;
  logic [XLEN-1:0]   rsp_rdata, force_rdata;
  bit                rsp_en;
  int                gnt_hold, rv_extra;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;
  cmd_t log_q[$];

  int n_chk = 0;
  int n_pass = 0;

  assign mem_gnt    = rsp_gnt;
  assign mem_rvalid = rsp_rvalid | force_rvalid;
  assign mem_rdata  = force_rvalid ? force_rdata : rsp_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_0104: return 32'h0010_8113;
      32'h0000_0108: return 32'h0020_81B3;
      32'h0000_0200: return 32'h00C0_0193;
      32'h0000_0300: return 32'h0000_0013;
      32'h0000_2000: return 32'hDEAD_BEEF;
      default:       return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Memory responder: gnt after gnt_hold cycles of mem_req, rvalid
  // rv_extra cycles after the cycle following gnt.
  initial begin
    bit          busy;
    int          rv_cnt, hold_cnt;
    logic [31:0] pend;
    cmd_t        c;
    busy = 0; rv_cnt = 0; hold_cnt = 0; pend = '0;
    rsp_gnt = 1'b0; rsp_rvalid = 1'b0; rsp_rdata = '0;
    forever begin
      @(negedge clk);
      rsp_gnt = 1'b0;
      rsp_rvalid = 1'b0;
      if (!rsp_en) begin
        busy = 0;
        hold_cnt = 0;
      end else if (busy) begin
        if (rv_cnt == 0) begin
          rsp_rvalid = 1'b1;
          rsp_rdata = pend;
          busy = 0;
        end else begin
          rv_cnt--;
        end
      end else if (mem_req) begin
        if (hold_cnt < gnt_hold) begin
          hold_cnt++;
        end else begin
          rsp_gnt = 1'b1;
          hold_cnt = 0;
          busy = 1;
          rv_cnt = rv_extra;
          pend = mem_we ? 32'h0 : rd_word(mem_addr);
          c.we = mem_we; c.addr = mem_addr; c.wdata = mem_wdata;
          log_q.push_back(c);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); #1;
    n_chk++; if (mem_req !== 1'b0) $display("FAIL reset.mem_req: got %b want 0", mem_req); else n_pass++;
    n_chk++; if (mem_we !== 1'b0) $display("FAIL reset.mem_we: got %b want 0", mem_we); else n_pass++;
    n_chk++; if ({if_valid, d_valid} !== 2'b00) $display("FAIL reset.valids: got %b want 00", {if_valid, d_valid}); else n_pass++;
    n_chk++; if ({mem_be, mem_addr, mem_wdata} !== '0) $display("FAIL reset.cmd_regs: got %h/%h/%h want 0", mem_be, mem_addr, mem_wdata); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_chk++; if (mem_req !== 1'b0) $display("FAIL reset.idle_req: got %b want 0", mem_req); else n_pass++;
  endtask

  task automatic test_lone_fetch();
    @(negedge clk); if_req = 1'b1; if_addr = 32'h100;
    #1;
    n_chk++; if ({stall_if, mem_req} !== 2'b10) $display("FAIL fetch.c0 stall_if/mem_req: got %b want 10", {stall_if, mem_req}); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h100}) $display("FAIL fetch.c1 cmd: got req=%b we=%b addr=%h want 1 0 100", mem_req, mem_we, mem_addr); else n_pass++;
    n_chk++; if ({stall_if, if_valid} !== 2'b10) $display("FAIL fetch.c1 stall_if/if_valid: got %b want 10", {stall_if, if_valid}); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (if_valid !== 1'b1) $display("FAIL fetch.c2 if_valid: got %b want 1", if_valid); else n_pass++;
    n_chk++; if (if_rdata !== 32'h0050_0093) $display("FAIL fetch.c2 if_rdata: got %h want 00500093", if_rdata); else n_pass++;
    n_chk++; if ({stall_if, mem_req, d_valid} !== 3'b000) $display("FAIL fetch.c2 stall_if/mem_req/d_valid: got %b want 000", {stall_if, mem_req, d_valid}); else n_pass++;
    @(negedge clk); if_req = 1'b0;
    #1;
    n_chk++; if (if_valid !== 1'b0) $display("FAIL fetch.c3 if_valid: got %b want 0", if_valid); else n_pass++;
  endtask

  task automatic test_conflict();
    int          d_cyc, i_cyc;
    bit          stall_ok;
    logic [31:0] d_data;
    d_cyc = -1; i_cyc = -1; stall_ok = 1; d_data = '0;
    log_q.delete();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h108;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h2000; d_wdata = '0;
    for (int c = 0; c < 20 && i_cyc < 0; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (d_cyc >= 0) d_req = 1'b0;
      end
      #1;
      if (d_valid && d_cyc < 0) begin d_cyc = c; d_data = d_rdata; end
      if (if_valid) i_cyc = c;
      else if (!stall_if) stall_ok = 0;
    end
    @(negedge clk); if_req = 1'b0;
    n_chk++; if (d_cyc !== 2) $display("FAIL conflict.d_valid_cycle: got %0d want 2", d_cyc); else n_pass++;
    n_chk++; if (d_data !== 32'hDEAD_BEEF) $display("FAIL conflict.d_rdata: got %h want deadbeef", d_data); else n_pass++;
    n_chk++; if (i_cyc !== 5) $display("FAIL conflict.if_valid_cycle: got %0d want 5", i_cyc); else n_pass++;
    n_chk++; if (stall_ok !== 1'b1) $display("FAIL conflict.stall_if_held: got %b want 1", stall_ok); else n_pass++;
    n_chk++; if (log_q.size() !== 2) $display("FAIL conflict.grants: got %0d want 2", log_q.size()); else n_pass++;
    if (log_q.size() >= 2) begin
      n_chk++; if ({log_q[0].we, log_q[0].addr} !== {1'b0, 32'h2000}) $display("FAIL conflict.first_cmd: got we=%b addr=%h want 0 2000", log_q[0].we, log_q[0].addr); else n_pass++;
      n_chk++; if ({log_q[1].we, log_q[1].addr} !== {1'b0, 32'h108}) $display("FAIL conflict.second_cmd: got we=%b addr=%h want 0 108", log_q[1].we, log_q[1].addr); else n_pass++;
    end
  endtask

  task automatic test_flush();
    int ifv_cnt;
    ifv_cnt = 0;
    rv_extra = 2;
    @(negedge clk); if_req = 1'b1; if_addr = 32'h104;
    #1; ifv_cnt += int'(if_valid);
    @(negedge clk); #1; ifv_cnt += int'(if_valid);          // c1: grant
    @(negedge clk); if_flush = 1'b1;                          // c2: WAIT
    #1; ifv_cnt += int'(if_valid);
    @(negedge clk); if_flush = 1'b0; if_addr = 32'h200;       // c3: new PC
    #1; ifv_cnt += int'(if_valid);
    @(negedge clk); #1;                                       // c4: stale response
    n_chk++; if ({if_valid, stall_if} !== 2'b01) $display("FAIL flush.c4 if_valid/stall_if: got %b want 01", {if_valid, stall_if}); else n_pass++;
    ifv_cnt += int'(if_valid);
    @(negedge clk); rv_extra = 0;                             // c5: IDLE latch
    #1; ifv_cnt += int'(if_valid);
    @(negedge clk); #1;                                       // c6: ISSUE
    n_chk++; if ({mem_req, mem_addr} !== {1'b1, 32'h200}) $display("FAIL flush.c6 cmd: got req=%b addr=%h want 1 200", mem_req, mem_addr); else n_pass++;
    ifv_cnt += int'(if_valid);
    n_chk++; if (ifv_cnt !== 0) $display("FAIL flush.swallowed: got %0d if_valid pulses want 0", ifv_cnt); else n_pass++;
    @(negedge clk); #1;                                       // c7: response
    n_chk++; if ({if_valid, if_rdata} !== {1'b1, 32'h00C0_0193}) $display("FAIL flush.c7 refetch: got v=%b data=%h want 1 00c00193", if_valid, if_rdata); else n_pass++;
    @(negedge clk); if_req = 1'b0;
  endtask

  task automatic test_starvation();
    int          k;
    bit          dv_prev, iv_prev, got_if;
    logic [31:0] if_data;
    logic        exp_we   [7];
    logic [31:0] exp_addr [7];
    logic [31:0] exp_wd   [7];
    k = 0; dv_prev = 0; iv_prev = 0; got_if = 0; if_data = '0;
    for (int i = 0; i < 7; i++) begin
      int s;
      s = (i < 4) ? i : i - 1;
      exp_we[i]   = (i != 4);
      exp_addr[i] = (i == 4) ? 32'h300 : 32'h3000 + 32'(4 * s);
      exp_wd[i]   = 32'hC0DE_0000 + 32'(s);
    end
    log_q.delete();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h3000; d_wdata = 32'hC0DE_0000;
    for (int c = 0; c < 60 && (k < 6 || !got_if); c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (dv_prev) begin
          k++;
          if (k < 6) begin
            d_addr  = 32'h3000 + 32'(4 * k);
            d_wdata = 32'hC0DE_0000 + 32'(k);
          end else begin
            d_req = 1'b0;
          end
        end
        if (iv_prev) if_req = 1'b0;
      end
      #1;
      dv_prev = d_valid;
      iv_prev = if_valid;
      if (if_valid) begin got_if = 1; if_data = if_rdata; end
    end
    @(negedge clk); d_req = 1'b0; if_req = 1'b0;
    n_chk++; if (k !== 6) $display("FAIL starve.stores_done: got %0d want 6", k); else n_pass++;
    n_chk++; if (if_data !== 32'h0000_0013) $display("FAIL starve.if_rdata: got %h want 00000013", if_data); else n_pass++;
    n_chk++; if (log_q.size() !== 7) $display("FAIL starve.grants: got %0d want 7", log_q.size()); else n_pass++;
    for (int i = 0; i < 7 && i < log_q.size(); i++) begin
      n_chk++;
      if ({log_q[i].we, log_q[i].addr} !== {exp_we[i], exp_addr[i]})
        $display("FAIL starve.order[%0d]: got we=%b addr=%h want we=%b addr=%h", i, log_q[i].we, log_q[i].addr, exp_we[i], exp_addr[i]);
      else n_pass++;
      if (exp_we[i]) begin
        n_chk++;
        if (log_q[i].wdata !== exp_wd[i]) $display("FAIL starve.wdata[%0d]: got %h want %h", i, log_q[i].wdata, exp_wd[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_gnt_stall();
    int dv_cnt, dv_cyc;
    bit stall_ok;
    dv_cnt = 0; dv_cyc = -1; stall_ok = 1;
    gnt_hold = 3;
    log_q.delete();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h4000; d_wdata = 32'h1234_5678;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (c == 6) d_req = 1'b0;
      end
      #1;
      if (d_valid) begin dv_cnt++; dv_cyc = c; end
      if (c <= 4 && !stall_mem) stall_ok = 0;
      if (c >= 1 && c <= 4) begin
        n_chk++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {2'b11, 4'b0011, 32'h4000, 32'h1234_5678})
          $display("FAIL gnt_stall.c%0d cmd: got req=%b we=%b be=%b addr=%h wd=%h want 1 1 0011 4000 12345678", c, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        else n_pass++;
      end
      if (c == 5) begin
        n_chk++; if ({mem_req, stall_mem} !== 2'b00) $display("FAIL gnt_stall.c5 mem_req/stall_mem: got %b want 00", {mem_req, stall_mem}); else n_pass++;
      end
    end
    gnt_hold = 0;
    n_chk++; if (dv_cnt !== 1) $display("FAIL gnt_stall.d_valid_count: got %0d want 1", dv_cnt); else n_pass++;
    n_chk++; if (dv_cyc !== 5) $display("FAIL gnt_stall.d_valid_cycle: got %0d want 5", dv_cyc); else n_pass++;
    n_chk++; if (log_q.size() !== 1) $display("FAIL gnt_stall.grants: got %0d want 1", log_q.size()); else n_pass++;
    n_chk++; if (stall_ok !== 1'b1) $display("FAIL gnt_stall.stall_mem_held: got %b want 1", stall_ok); else n_pass++;
  endtask

  task automatic test_reset_mid();
    rv_extra = 3;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h2000; d_wdata = '0;
    @(negedge clk);                                           // c1: grant
    @(negedge clk); rst_n = 1'b0; rsp_en = 0; d_req = 1'b0;   // c2: WAIT, reset
    #1;
    n_chk++; if ({mem_req, if_valid, d_valid, stall_mem} !== 4'b0000) $display("FAIL rst_mid.outputs: got %b want 0000", {mem_req, if_valid, d_valid, stall_mem}); else n_pass++;
    n_chk++; if ({mem_we, mem_addr} !== 33'h0) $display("FAIL rst_mid.cmd: got we=%b addr=%h want 0 0", mem_we, mem_addr); else n_pass++;
    @(negedge clk); rst_n = 1'b1;                             // c3
    @(negedge clk); force_rvalid = 1'b1; force_rdata = 32'hBAD0_BAD0;  // c4: stray
    #1;
    n_chk++; if ({if_valid, d_valid} !== 2'b00) $display("FAIL rst_mid.stray_rvalid: got %b want 00", {if_valid, d_valid}); else n_pass++;
    @(negedge clk); force_rvalid = 1'b0; rv_extra = 0;        // c5
    #1;
    n_chk++; if ({mem_req, if_valid, d_valid} !== 3'b000) $display("FAIL rst_mid.after_stray: got %b want 000", {mem_req, if_valid, d_valid}); else n_pass++;
    @(negedge clk); rsp_en = 1; if_req = 1'b1; if_addr = 32'h100;  // c6: IDLE latch
    @(negedge clk); #1;                                       // c7
    n_chk++; if ({mem_req, mem_addr} !== {1'b1, 32'h100}) $display("FAIL rst_mid.new_cmd: got req=%b addr=%h want 1 100", mem_req, mem_addr); else n_pass++;
    @(negedge clk); #1;                                       // c8
    n_chk++; if ({if_valid, if_rdata} !== {1'b1, 32'h0050_0093}) $display("FAIL rst_mid.new_fetch: got v=%b data=%h want 1 00500093", if_valid, if_rdata); else n_pass++;
    @(negedge clk); if_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    force_rvalid = 1'b0; force_rdata = '0;
    rsp_en = 1; gnt_hold = 0; rv_extra = 0;

    test_reset();
    test_lone_fetch();
    idle(2);
    test_conflict();
    idle(2);
    test_flush();
    idle(2);
    test_starvation();
    idle(2);
    test_gnt_stall();
    idle(2);
    test_reset_mid();
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
